// File: rtl/align_normalize_iter_if.sv
// Handshake bundle for align_normalize_iter: the accumulated-sum input stream and
// the normalized sign/exponent/mantissa result stream.
interface align_normalize_iter_if #(
  parameter int IN_W  = 19,
  parameter int EXP_W = 6
);
  // Both streams: a beat transfers on a rising edge where valid and ready are both
  // high; the source holds valid and payload stable until that edge, and ready may
  // be driven independently of valid.
  logic             i_valid;
  logic             o_ready;
  logic [IN_W-1:0]  i_sum;
  logic [EXP_W-1:0] i_max_exp;
  logic             o_valid;
  logic             i_ready;
  logic             o_sign;
  logic [EXP_W-1:0] o_exp;
  logic [2:0]       o_man;
  logic             o_zero;
  logic             o_ovf;

  modport master (
    output i_valid, i_sum, i_max_exp, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_man, o_zero, o_ovf
  );

  modport slave (
    input  i_valid, i_sum, i_max_exp, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_man, o_zero, o_ovf
  );
endinterface

// File: rtl/align_normalize_iter.sv
// Iterative normalizer: signed aligned sum -> sign / exponent / 3-bit mantissa with
// round-to-nearest-even, one normalizing shift per cycle.
module align_normalize_iter #(
  parameter int IN_W  = 19,
  parameter int POINT = 13,
  parameter int EXP_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  align_normalize_iter_if.slave io_bus,
  output logic [2:0]            o_state,
  output logic [50:0]           number
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ABS   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [IN_W-1:0]  r_mag;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic             r_sticky;
  logic             r_valid;
  logic             r_osign;
  logic [EXP_W-1:0] r_oexp;
  logic [2:0]       r_oman;
  logic             r_zero;
  logic             r_ovf;

  logic [IN_W-1:0]  w_abs;
  logic             w_above;
  logic             w_exp_max;
  logic [2:0]       w_man;
  logic             w_g;
  logic             w_s;
  logic             w_inc;
  logic [3:0]       w_man_rnd;

  // r_mag holds the raw latched sum until ABS replaces it with its magnitude.
  assign w_abs     = r_sign ? (~r_mag + 1'b1) : r_mag;
  assign w_above   = |r_mag[IN_W-1:POINT+1];
  assign w_exp_max = (r_exp == {EXP_W{1'b1}});
  assign w_man     = r_mag[POINT -: 3];
  assign w_g       = r_mag[POINT-3];
  assign w_s       = (|r_mag[POINT-4:0]) | r_sticky;
  assign w_inc     = w_g & (w_s | w_man[0]);
  assign w_man_rnd = {1'b0, w_man} + {3'b000, w_inc};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_mag    <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
      r_valid  <= 1'b0;
      r_osign  <= 1'b0;
      r_oexp   <= '0;
      r_oman   <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_valid) begin
            r_mag    <= io_bus.i_sum;
            r_exp    <= io_bus.i_max_exp;
            r_sign   <= io_bus.i_sum[IN_W-1];
            r_sticky <= 1'b0;
            r_state  <= S_ABS;
          end
        end
        S_ABS: begin
          if (w_abs == '0) begin
            r_valid <= 1'b1;
            r_osign <= 1'b0;
            r_oexp  <= '0;
            r_oman  <= '0;
            r_zero  <= 1'b1;
            r_ovf   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_mag   <= w_abs;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (w_above) begin
            if (w_exp_max) begin
              r_valid <= 1'b1;
              r_osign <= r_sign;
              r_oexp  <= {EXP_W{1'b1}};
              r_oman  <= 3'b111;
              r_zero  <= 1'b0;
              r_ovf   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_mag    <= r_mag >> 1;
              r_sticky <= r_sticky | r_mag[0];
              r_exp    <= r_exp + 1'b1;
            end
          end else if (!r_mag[POINT]) begin
            // Exponent exhausted before the leading one reached POINT: flush, keep sign.
            if (r_exp == '0) begin
              r_valid <= 1'b1;
              r_osign <= r_sign;
              r_oexp  <= '0;
              r_oman  <= '0;
              r_zero  <= 1'b1;
              r_ovf   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_mag <= r_mag << 1;
              r_exp <= r_exp - 1'b1;
            end
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_valid <= 1'b1;
          r_osign <= r_sign;
          r_zero  <= 1'b0;
          r_state <= S_DONE;
          if (w_man_rnd[3]) begin
            if (w_exp_max) begin
              r_oexp <= {EXP_W{1'b1}};
              r_oman <= 3'b111;
              r_ovf  <= 1'b1;
            end else begin
              r_oexp <= r_exp + 1'b1;
              r_oman <= 3'b100;
              r_ovf  <= 1'b0;
            end
          end else begin
            r_oexp <= r_exp;
            r_oman <= w_man_rnd[2:0];
            r_ovf  <= 1'b0;
          end
        end
        S_DONE: begin
          if (io_bus.i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.o_ready = (r_state == S_IDLE) && !i_rst;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_sign  = r_osign;
  assign io_bus.o_exp   = r_oexp;
  assign io_bus.o_man   = r_oman;
  assign io_bus.o_zero  = r_zero;
  assign io_bus.o_ovf   = r_ovf;
  assign o_state        = r_state;
  // No cell-library submodules are instantiated here, so the tally is empty.
  assign number         = '0;
endmodule

// File: tb/tb_align_normalize_iter.sv
// Randomized scoreboard bench for align_normalize_iter against an arithmetic
// reference of sign/exponent/round-to-nearest-even mantissa.
module tb_align_normalize_iter;
  localparam int IN_W  = 19;
  localparam int POINT = 13;
  localparam int EXP_W = 6;

  logic        clk;
  logic        rst;
  logic [2:0]  o_state;
  logic [50:0] number;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          rdy_mode;
  bit          first_seen;

  logic [11:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic [24:0] info_q[$];

  align_normalize_iter_if #(.IN_W(IN_W), .EXP_W(EXP_W)) bus ();

  align_normalize_iter #(.IN_W(IN_W), .POINT(POINT), .EXP_W(EXP_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .io_bus  (bus),
    .o_state (o_state),
    .number  (number)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  // Reference: value = sum * 2^(max_exp - POINT), rounded to 3 significant bits.
  function automatic void ref_model(input logic [IN_W-1:0] sum, input logic [EXP_W-1:0] mexp,
                                    output logic [11:0] res, output int lat);
    int a, p, e, q, rem, half;
    bit s, up;
    s = sum[IN_W-1];
    a = s ? ((1 << IN_W) - int'(sum)) : int'(sum);
    if (a == 0) begin
      res = {1'b0, 6'd0, 3'd0, 1'b1, 1'b0};
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < IN_W; i++) if (a[i]) p = i;
    e = int'(mexp) + p - POINT;
    if (e < 0) begin
      res = {s, 6'd0, 3'd0, 1'b1, 1'b0};
      lat = -1;
      return;
    end
    if (e > 63) begin
      res = {s, 6'h3f, 3'b111, 1'b0, 1'b1};
      lat = -1;
      return;
    end
    up = 1'b0;
    if (p >= 2) begin
      q   = a >> (p - 2);
      rem = a - (q << (p - 2));
      if (p >= 3) begin
        half = 1 << (p - 3);
        up = (rem > half) || ((rem == half) && q[0]);
      end
    end else begin
      q = a << (2 - p);
    end
    if (up) q++;
    if (q == 8) begin
      q = 4;
      e++;
    end
    lat = ((p > POINT) ? (p - POINT) : (POINT - p)) + 4;
    if (e > 63) res = {s, 6'h3f, 3'b111, 1'b0, 1'b1};
    else        res = {s, e[5:0], q[2:0], 1'b0, 1'b0};
  endfunction

  // driver
  task automatic send(input logic [IN_W-1:0] s, input logic [EXP_W-1:0] e);
    logic [11:0] r;
    int          l;
    int          n;
    bit          acc;
    @(posedge clk);
    #1;
    bus.i_valid   = 1'b1;
    bus.i_sum     = s;
    bus.i_max_exp = e;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (bus.o_ready) acc = 1'b1;
      else n++;
    end
    if (acc) begin
      ref_model(s, e, r, l);
      exp_q.push_back(r);
      lat_q.push_back(l);
      acc_q.push_back(cyc + 1);
      info_q.push_back({s, e});
      @(posedge clk);
      #1;
    end else begin
      n_checks++;
      $display("FAIL accept timeout: sum=%0h exp=%0d not accepted, expected accept", s, e);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  // downstream ready
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = 1'($urandom_range(0, 1));
        default: bus.i_ready = 1'b0;
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    logic [11:0] got;
    logic [11:0] want;
    logic [24:0] info;
    first_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        first_seen = 1'b0;
      end else begin
        if (bus.o_valid && !first_seen && lat_q.size() > 0) begin
          first_seen = 1'b1;
          if (lat_q[0] >= 0)
            check($sformatf("latency sum=%0h exp=%0d", info_q[0][24:6], info_q[0][5:0]),
                  32'(cyc + 1 - acc_q[0]), 32'(lat_q[0]));
        end
        if (bus.o_valid && bus.i_ready) begin
          got = {bus.o_sign, bus.o_exp, bus.o_man, bus.o_zero, bus.o_ovf};
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected output: got %0h, expected no result", got);
          end else begin
            want = exp_q.pop_front();
            info = info_q.pop_front();
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            check($sformatf("result {s,exp,man,z,ovf} sum=%0h exp=%0d", info[24:6], info[5:0]),
                  32'(got), 32'(want));
          end
          first_seen = 1'b0;
        end
      end
    end
  end

  // main sequence
  logic [IN_W-1:0]  dir_sum [12];
  logic [EXP_W-1:0] dir_exp [12];

  initial begin
    logic [IN_W-1:0] v;
    int              k;
    int              guard;
    n_checks      = 0;
    n_pass        = 0;
    rdy_mode      = 0;
    rst           = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_sum     = '0;
    bus.i_max_exp = '0;
    dir_sum = '{19'h02000, 19'h7C800, 19'h0F000, 19'h02400, 19'h02C00, 19'h00001,
                19'h00001, 19'h00000, 19'h04000, 19'h40000, 19'h7FFFF, 19'h03E00};
    dir_exp = '{6'd20, 6'd20, 6'd10, 6'd20, 6'd20, 6'd20,
                6'd5, 6'd20, 6'd63, 6'd10, 6'd0, 6'd63};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("o_ready in reset", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs", 32'({bus.o_valid, bus.o_sign, bus.o_exp, bus.o_man, bus.o_zero, bus.o_ovf}), 32'd0);
    check("reset state", 32'(o_state), 32'd0);
    check("o_ready after reset", 32'(bus.o_ready), 32'd1);

    // directed cases
    for (int i = 0; i < 12; i++) send(dir_sum[i], dir_exp[i]);
    drain();

    // backpressure: result must hold while downstream stalls
    rdy_mode = 2;
    send(19'h02000, 6'd20);
    guard = 0;
    while (!bus.o_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.i_valid = 1'b1;
        bus.i_sum   = 19'h01000;
      end
      check("stall o_valid", 32'(bus.o_valid), 32'd1);
      check("stall payload", 32'({bus.o_sign, bus.o_exp, bus.o_man, bus.o_zero, bus.o_ovf}),
            32'({1'b0, 6'd20, 3'b100, 1'b0, 1'b0}));
      check("stall o_ready", 32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    rdy_mode = 0;
    drain();
    repeat (3) @(negedge clk);
    check("no extra result", 32'(bus.o_valid), 32'd0);
    check("idle after stall", 32'(bus.o_ready), 32'd1);

    // reset mid-normalization
    send(19'h00001, 6'd20);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    info_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid-norm reset state", 32'(o_state), 32'd0);
    check("mid-norm reset outputs", 32'({bus.o_valid, bus.o_sign, bus.o_exp, bus.o_man, bus.o_zero, bus.o_ovf}), 32'd0);
    check("mid-norm reset o_ready", 32'(bus.o_ready), 32'd1);

    // randomized traffic with random downstream ready
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, IN_W);
      v = IN_W'($urandom);
      if (k < IN_W) v = v & ((IN_W'(1) << k) - IN_W'(1));
      if ($urandom_range(0, 1) == 1) v = -v;
      send(v, EXP_W'($urandom_range(0, 63)));
    end
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
